// File: rtl/exfil_pkg.sv
// -----------------------------------------------------------------------------
// exfil_pkg
// Shared types and constants for the exfiltration transmit stage.
//   drain_state_t : states of the FT240X drain FSM
//   EXFIL_PAGE_W  : width of the exfiltration page (target address bits 17:8)
//   DROP_CNT_W    : width of the saturating dropped-byte counter
// Optional feature macro used by importers: EXFIL_DROP_COUNT_EN
// -----------------------------------------------------------------------------
package exfil_pkg;

    localparam int EXFIL_PAGE_W = 10;
    localparam int DROP_CNT_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SETUP,
        STROBE,
        HOLD,
        GAP
    } drain_state_t;

endpackage

// File: rtl/exfil_fifo.sv
// -----------------------------------------------------------------------------
// exfil_fifo
// Synchronous FIFO holding captured address bytes until the drain FSM writes
// them to the FT240X. Push and pop in the same cycle are both honoured, even
// when full (the pop frees the slot the push lands in).
// Ports:
//   clk24MHz   in  system clock
//   rst        in  synchronous active-high reset (pointers only)
//   push       in  write push_data this cycle
//   push_data  in  WIDTH-bit byte to queue
//   pop        in  discard head this cycle
//   full       out FIFO holds DEPTH entries
//   empty      out FIFO holds no entries
//   head       out oldest entry
// -----------------------------------------------------------------------------
module exfil_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk24MHz,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the low bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk24MHz) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk24MHz) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/exfil_tx.sv
// -----------------------------------------------------------------------------
// exfil_tx
// Exfiltration transmit stage. Watches target read cycles, captures the low
// address byte of each access that falls in the programmed page, queues it and
// drains the queue to the FT240X with timed nWR strobes after winning the
// shared data bus.
// Ports:
//   clk24MHz            in  24 MHz system clock
//   rst                 in  synchronous active-high reset
//   enable              in  capture enable
//   match_page          in  page compared against tgt_addr[17:8]
//   tgt_addr            in  target address bus
//   tgt_nCE/nOEL/nOEH   in  asynchronous target strobes
//   clr_stats           in  pulse clearing overflow and drop_count
//   ft240x_TXE          in  FT240X TX FIFO full
//   bus_gnt             in  data-bus grant
//   bus_req             out data-bus request
//   ft_d_out            out byte driven onto ft240x_d
//   ft_d_oe             out drive enable for ft240x_d
//   ft240x_nWR          out FT240X write strobe, active low
//   overflow            out sticky dropped-byte flag
//   drop_count          out saturating dropped-byte count
// Macro EXFIL_DROP_COUNT_EN: when defined the drop counter is built, otherwise
// drop_count is tied to zero.
// -----------------------------------------------------------------------------
module exfil_tx
    import exfil_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int WR_LOW_CYC = 1,
    parameter int WR_GAP_CYC = 1
) (
    input  logic                    clk24MHz,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [EXFIL_PAGE_W-1:0] match_page,
    input  logic [17:0]             tgt_addr,
    input  logic                    tgt_nCE,
    input  logic                    tgt_nOEL,
    input  logic                    tgt_nOEH,
    input  logic                    clr_stats,
    input  logic                    ft240x_TXE,
    input  logic                    bus_gnt,
    output logic                    bus_req,
    output logic [7:0]              ft_d_out,
    output logic                    ft_d_oe,
    output logic                    ft240x_nWR,
    output logic                    overflow,
    output logic [DROP_CNT_W-1:0]   drop_count
);

    localparam logic [7:0] LOW_LAST = 8'(WR_LOW_CYC - 1);
    localparam logic [7:0] GAP_LAST = 8'(WR_GAP_CYC - 1);

    logic         nce_p0, noel_p0, noeh_p0;
    logic         nce_p1, noel_p1, noeh_p1;
    logic         access_p1;
    logic         access_p2;
    logic         access_start;
    logic         push_p2;
    logic [7:0]   push_data_p2;

    logic         fifo_full;
    logic         fifo_empty;
    logic [7:0]   fifo_head;
    logic         pop;
    logic         drop;

    drain_state_t state, state_nxt;
    logic [7:0]   cnt, cnt_nxt;
    logic         req_nxt, oe_nxt, nwr_nxt;

    // ---- stage p0/p1: two-flop synchronisers on the asynchronous strobes ----
    always_ff @(posedge clk24MHz) begin
        if (rst) begin
            {nce_p0, noel_p0, noeh_p0} <= 3'b111;
            {nce_p1, noel_p1, noeh_p1} <= 3'b111;
        end else begin
            {nce_p0, noel_p0, noeh_p0} <= {tgt_nCE, tgt_nOEL, tgt_nOEH};
            {nce_p1, noel_p1, noeh_p1} <= {nce_p0, noel_p0, noeh_p0};
        end
    end

    assign access_p1    = !nce_p1 && (!noel_p1 || !noeh_p1);
    assign access_start = access_p1 && !access_p2;

    // ---- stage p2: edge detect, page compare, registered push ----
    always_ff @(posedge clk24MHz) begin
        if (rst) begin
            access_p2 <= 1'b0;
            push_p2   <= 1'b0;
        end else begin
            access_p2 <= access_p1;
            push_p2   <= access_start && enable && (tgt_addr[17:8] == match_page);
        end
    end

    always_ff @(posedge clk24MHz) begin
        push_data_p2 <= tgt_addr[7:0];
    end

    exfil_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk24MHz  (clk24MHz),
        .rst       (rst),
        .push      (push_p2),
        .push_data (push_data_p2),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // HOLD lasts one cycle and is only reached with a byte at the head.
    assign pop  = (state == HOLD);
    assign drop = push_p2 && fifo_full && !pop;

    // Drop takes priority over clear so a coincident drop is never lost.
    always_ff @(posedge clk24MHz) begin
        if (rst)            overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (clr_stats) overflow <= 1'b0;
    end

`ifdef EXFIL_DROP_COUNT_EN
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk24MHz) begin
        if (rst)            drop_count <= '0;
        else if (clr_stats) drop_count <= drop ? DROP_CNT_W'(1) : '0;
        else if (drop)      drop_count <= sat_inc(drop_count);
    end
`else
    assign drop_count = '0;
`endif

    // ---- drain FSM: next state and next registered outputs ----
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 8'd1;
        case (state)
            IDLE:    if (!fifo_empty)              state_nxt = REQ;
            REQ:     if (bus_gnt && !ft240x_TXE)   state_nxt = SETUP;
            SETUP:                                 state_nxt = STROBE;
            STROBE:  if (cnt == LOW_LAST)          state_nxt = HOLD;
            HOLD:                                  state_nxt = GAP;
            GAP:     if (cnt == GAP_LAST)          state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
        if (state_nxt != state) cnt_nxt = '0;
        req_nxt = state_nxt inside {REQ, SETUP, STROBE, HOLD};
        oe_nxt  = state_nxt inside {SETUP, STROBE, HOLD};
        nwr_nxt = (state_nxt != STROBE);
    end

    // Outputs are registered from the next state so they change with the state.
    always_ff @(posedge clk24MHz) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bus_req    <= 1'b0;
            ft_d_oe    <= 1'b0;
            ft240x_nWR <= 1'b1;
            ft_d_out   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bus_req    <= req_nxt;
            ft_d_oe    <= oe_nxt;
            ft240x_nWR <= nwr_nxt;
            if (state_nxt == SETUP && state != SETUP) ft_d_out <= fifo_head;
        end
    end

endmodule

// File: tb/tb_exfil_tx.sv
// -----------------------------------------------------------------------------
// tb_exfil_tx
// Directed self-checking bench for exfil_tx (default parameters).
// -----------------------------------------------------------------------------
module tb_exfil_tx;

    logic        clk24MHz = 1'b0;
    logic        rst;
    logic        enable;
    logic [9:0]  match_page;
    logic [17:0] tgt_addr;
    logic        tgt_nCE, tgt_nOEL, tgt_nOEH;
    logic        clr_stats;
    logic        ft240x_TXE;
    logic        bus_gnt;
    logic        bus_req;
    logic [7:0]  ft_d_out;
    logic        ft_d_oe;
    logic        ft240x_nWR;
    logic        overflow;
    logic [7:0]  drop_count;

`ifdef EXFIL_DROP_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int checks = 0;
    int fails  = 0;

    // write monitor state
    logic [7:0] wr_data[$];
    int         wr_cyc[$];
    int         cyc = 0;
    int         nwr_low = 0;
    int         oe_hi = 0;
    int         req_hi = 0;
    logic       prev_nwr = 1'b1;

    always #21 clk24MHz = ~clk24MHz;

    exfil_tx #(
        .DEPTH      (8),
        .WR_LOW_CYC (1),
        .WR_GAP_CYC (1)
    ) dut (
        .clk24MHz   (clk24MHz),
        .rst        (rst),
        .enable     (enable),
        .match_page (match_page),
        .tgt_addr   (tgt_addr),
        .tgt_nCE    (tgt_nCE),
        .tgt_nOEL   (tgt_nOEL),
        .tgt_nOEH   (tgt_nOEH),
        .clr_stats  (clr_stats),
        .ft240x_TXE (ft240x_TXE),
        .bus_gnt    (bus_gnt),
        .bus_req    (bus_req),
        .ft_d_out   (ft_d_out),
        .ft_d_oe    (ft_d_oe),
        .ft240x_nWR (ft240x_nWR),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    // Records each byte on the nWR falling edge plus strobe/enable cycle counts.
    always @(negedge clk24MHz) begin
        cyc = cyc + 1;
        if (!ft240x_nWR && prev_nwr) begin
            wr_data.push_back(ft_d_out);
            wr_cyc.push_back(cyc);
        end
        if (!ft240x_nWR) nwr_low = nwr_low + 1;
        if (ft_d_oe)     oe_hi   = oe_hi + 1;
        if (bus_req)     req_hi  = req_hi + 1;
        prev_nwr = ft240x_nWR;
    end

    function automatic logic [7:0] wr_at(input int i);
        return (i < wr_data.size()) ? wr_data[i] : 8'hxx;
    endfunction

    task automatic clear_mon();
        wr_data.delete();
        wr_cyc.delete();
        nwr_low = 0;
        oe_hi   = 0;
        req_hi  = 0;
    endtask

    task automatic pulse_clr();
        @(negedge clk24MHz) clr_stats = 1'b1;
        @(negedge clk24MHz) clr_stats = 1'b0;
    endtask

    // One target access; optionally raise clr_stats in the cycle the push lands.
    task automatic access(input logic [17:0] a, input bit clr_at_push);
        @(negedge clk24MHz) tgt_addr = a;
        repeat (2) @(negedge clk24MHz);
        tgt_nCE = 1'b0; tgt_nOEL = 1'b0;
        repeat (3) @(negedge clk24MHz);
        if (clr_at_push) clr_stats = 1'b1;
        @(negedge clk24MHz) clr_stats = 1'b0;
        tgt_nCE = 1'b1; tgt_nOEL = 1'b1;
        repeat (4) @(negedge clk24MHz);
    endtask

    task automatic test_reset();
        checks++; if (bus_req !== 1'b0)    begin fails++; $display("FAIL reset_bus_req got %b want 0", bus_req); end
        checks++; if (ft_d_oe !== 1'b0)    begin fails++; $display("FAIL reset_oe got %b want 0", ft_d_oe); end
        checks++; if (ft_d_out !== 8'h00)  begin fails++; $display("FAIL reset_d_out got %h want 00", ft_d_out); end
        checks++; if (ft240x_nWR !== 1'b1) begin fails++; $display("FAIL reset_nwr got %b want 1", ft240x_nWR); end
        checks++; if (overflow !== 1'b0)   begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (drop_count !== 8'd0) begin fails++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
    endtask

    task automatic test_single();
        int  lat;
        bit  found;
        enable = 1'b1; match_page = 10'h3A5; bus_gnt = 1'b1; ft240x_TXE = 1'b0;
        clear_mon();
        @(negedge clk24MHz) tgt_addr = 18'h3A512;
        repeat (2) @(negedge clk24MHz);
        tgt_nCE = 1'b0; tgt_nOEL = 1'b0;
        lat = 0; found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk24MHz);
            lat++;
            if (!ft240x_nWR) found = 1'b1;
        end
        checks++; if (!found || lat != 7) begin fails++; $display("FAIL single_latency got %0d (found=%0d) want 7", lat, found); end
        // Keep the access asserted well past the write: it must not re-push.
        repeat (6) @(negedge clk24MHz);
        tgt_nCE = 1'b1; tgt_nOEL = 1'b1;
        repeat (15) @(negedge clk24MHz);
        checks++; if (wr_data.size() != 1) begin fails++; $display("FAIL single_count got %0d want 1", wr_data.size()); end
        checks++; if (wr_at(0) !== 8'h12)  begin fails++; $display("FAIL single_data got %h want 12", wr_at(0)); end
        checks++; if (nwr_low != 1)        begin fails++; $display("FAIL single_nwr_low got %0d want 1", nwr_low); end
        checks++; if (oe_hi != 3)          begin fails++; $display("FAIL single_oe_cycles got %0d want 3", oe_hi); end
    endtask

    task automatic test_nomatch();
        clear_mon();
        access(18'h3A612, 1'b0);
        enable = 1'b0;
        access(18'h3A512, 1'b0);
        repeat (10) @(negedge clk24MHz);
        checks++; if (req_hi != 0)         begin fails++; $display("FAIL nomatch_bus_req cycles got %0d want 0", req_hi); end
        checks++; if (wr_data.size() != 0) begin fails++; $display("FAIL nomatch_writes got %0d want 0", wr_data.size()); end
        enable = 1'b1;
    endtask

    task automatic test_overflow();
        ft240x_TXE = 1'b1; bus_gnt = 1'b1;
        clear_mon();
        pulse_clr();
        for (int i = 0; i < 10; i++) access({10'h3A5, 8'(i)}, 1'b0);
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (drop_count !== (CNT_EN ? 8'd2 : 8'd0)) begin fails++; $display("FAIL ovf_drop_count got %0d want %0d", drop_count, CNT_EN ? 2 : 0); end
        checks++; if (wr_data.size() != 0) begin fails++; $display("FAIL ovf_writes_while_txe got %0d want 0", wr_data.size()); end
        // A drop in the same cycle as clr_stats leaves one counted drop.
        access(18'h3A50A, 1'b1);
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL clr_drop_flag got %b want 1", overflow); end
        checks++; if (drop_count !== (CNT_EN ? 8'd1 : 8'd0)) begin fails++; $display("FAIL clr_drop_count got %0d want %0d", drop_count, CNT_EN ? 1 : 0); end
        ft240x_TXE = 1'b0;
        repeat (70) @(negedge clk24MHz);
        checks++; if (wr_data.size() != 8) begin fails++; $display("FAIL ovf_drain_count got %0d want 8", wr_data.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (wr_at(i) !== 8'(i)) begin fails++; $display("FAIL ovf_drain_order[%0d] got %h want %h", i, wr_at(i), 8'(i)); end
        end
        checks++;
        if (wr_cyc.size() < 2 || (wr_cyc[1] - wr_cyc[0]) != 6) begin
            fails++; $display("FAIL sustained_rate got %0d want 6", (wr_cyc.size() < 2) ? -1 : wr_cyc[1] - wr_cyc[0]);
        end
        pulse_clr();
        checks++; if (overflow !== 1'b0)   begin fails++; $display("FAIL clr_overflow got %b want 0", overflow); end
        checks++; if (drop_count !== 8'd0) begin fails++; $display("FAIL clr_drop_count0 got %0d want 0", drop_count); end
    endtask

    task automatic test_full_pop();
        ft240x_TXE = 1'b1; bus_gnt = 1'b1;
        clear_mon();
        pulse_clr();
        for (int i = 0; i < 8; i++) access({10'h3A5, 8'(8'h20 + i)}, 1'b0);
        // Release TXE and start the access together: the push lands on the HOLD pop.
        @(negedge clk24MHz) tgt_addr = 18'h3A5AA;
        repeat (2) @(negedge clk24MHz);
        ft240x_TXE = 1'b0; tgt_nCE = 1'b0; tgt_nOEL = 1'b0;
        repeat (4) @(negedge clk24MHz);
        tgt_nCE = 1'b1; tgt_nOEL = 1'b1;
        repeat (70) @(negedge clk24MHz);
        checks++; if (overflow !== 1'b0)   begin fails++; $display("FAIL fullpop_overflow got %b want 0", overflow); end
        checks++; if (drop_count !== 8'd0) begin fails++; $display("FAIL fullpop_drop_count got %0d want 0", drop_count); end
        checks++; if (wr_data.size() != 9) begin fails++; $display("FAIL fullpop_count got %0d want 9", wr_data.size()); end
        checks++; if (wr_at(0) !== 8'h20)  begin fails++; $display("FAIL fullpop_first got %h want 20", wr_at(0)); end
        checks++; if (wr_at(8) !== 8'hAA)  begin fails++; $display("FAIL fullpop_last got %h want aa", wr_at(8)); end
    endtask

    task automatic test_gnt_withheld();
        bit ok_req, ok_nwr;
        ft240x_TXE = 1'b0; bus_gnt = 1'b0;
        clear_mon();
        access(18'h3A533, 1'b0);
        ok_req = 1'b1; ok_nwr = 1'b1;
        repeat (20) begin
            @(negedge clk24MHz);
            if (bus_req !== 1'b1)    ok_req = 1'b0;
            if (ft240x_nWR !== 1'b1) ok_nwr = 1'b0;
        end
        checks++; if (!ok_req) begin fails++; $display("FAIL nognt_bus_req_held got 0 want 1"); end
        checks++; if (!ok_nwr) begin fails++; $display("FAIL nognt_nwr_high got 0 want 1"); end
        bus_gnt = 1'b1;
        repeat (15) @(negedge clk24MHz);
        checks++; if (wr_data.size() != 1) begin fails++; $display("FAIL gnt_count got %0d want 1", wr_data.size()); end
        checks++; if (wr_at(0) !== 8'h33)  begin fails++; $display("FAIL gnt_data got %h want 33", wr_at(0)); end
    endtask

    task automatic test_reset_mid();
        bit found, ok_idle;
        int n;
        ft240x_TXE = 1'b0; bus_gnt = 1'b0;
        clear_mon();
        access(18'h3A544, 1'b0);
        access(18'h3A555, 1'b0);
        bus_gnt = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk24MHz);
            if (!ft240x_nWR) found = 1'b1;
        end
        checks++; if (!found) begin fails++; $display("FAIL rstmid_strobe_seen got 0 want 1"); end
        rst = 1'b1;
        @(negedge clk24MHz);
        checks++; if (ft240x_nWR !== 1'b1) begin fails++; $display("FAIL rstmid_nwr got %b want 1", ft240x_nWR); end
        checks++; if (ft_d_oe !== 1'b0)    begin fails++; $display("FAIL rstmid_oe got %b want 0", ft_d_oe); end
        checks++; if (bus_req !== 1'b0)    begin fails++; $display("FAIL rstmid_bus_req got %b want 0", bus_req); end
        rst = 1'b0;
        n = wr_data.size();
        ok_idle = 1'b1;
        repeat (30) begin
            @(negedge clk24MHz);
            if (bus_req !== 1'b0) ok_idle = 1'b0;
        end
        checks++; if (!ok_idle) begin fails++; $display("FAIL rstmid_fifo_discarded got bus_req 1 want 0"); end
        checks++; if (wr_data.size() != n) begin fails++; $display("FAIL rstmid_no_more_writes got %0d want %0d", wr_data.size(), n); end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0; match_page = '0; tgt_addr = '0;
        tgt_nCE = 1'b1; tgt_nOEL = 1'b1; tgt_nOEH = 1'b1;
        clr_stats = 1'b0; ft240x_TXE = 1'b0; bus_gnt = 1'b0;
        repeat (3) @(negedge clk24MHz);
        rst = 1'b0;
        @(negedge clk24MHz);
        test_reset();
        test_single();
        test_nomatch();
        test_overflow();
        test_full_pop();
        test_gnt_withheld();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/exfil_tx.md
# exfil_tx

Exfiltration transmit stage: sits downstream of the ROM-emulator core, between the target bus and the FT240X write side. It watches target read cycles and captures the low address byte of every access whose address bits 17:8 match the programmed exfiltration page. Captured bytes go into a small FIFO, which is drained to the FT240X with properly timed nWR strobes. The FT240X data bus is shared with the command-read path, so this block requests the bus before writing.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..16.
- WR_LOW_CYC, 1: clock cycles nWR is held low per byte.
- WR_GAP_CYC, 1: clock cycles between releasing the bus and the next request.

Ports (one clock, clk24MHz; reset is synchronous and active-high):
- clk24MHz  in  1  24 MHz system clock.
- rst  in  1  Synchronous reset, active-high.
- enable  in  1  Exfiltration enable; when high, matching accesses are captured.
- match_page  in  10  Exfiltration page, compared against address bits 17:8.
- tgt_addr  in  18  Target address bus (valid in run mode).
- tgt_nCE, tgt_nOEL, tgt_nOEH  in  1 each  Target strobes; asynchronous.
- clr_stats  in  1  Single-cycle pulse; clears overflow and drop_count.
- ft240x_TXE  in  1  High means the FT240X TX FIFO is full.
- bus_gnt  in  1  FT240X data-bus grant from the command path.
- bus_req  out  1  FT240X data-bus request.
- ft_d_out  out  8  Byte to drive onto ft240x_d.
- ft_d_oe  out  1  Drive enable for ft240x_d.
- ft240x_nWR  out  1  FT240X write strobe, active low.
- overflow  out  1  Sticky flag: a byte was dropped because the FIFO was full.
- drop_count  out  8  Saturating count of dropped bytes.

## Operation
- Strobe synchronisation:
  - tgt_nCE, tgt_nOEL and tgt_nOEH each pass through a 2-flop synchroniser.
  - access = !nCE_s && (!nOEL_s || !nOEH_s).
  - Access start is the cycle in which access rises from 0 to 1.
- Capture:
  - On access start, tgt_addr is sampled. It has been stable for at least 2 cycles by then.
  - If enable is high and tgt_addr[17:8] == match_page, tgt_addr[7:0] is pushed.
  - At most one push per access start; a long access does not re-push.
- Full FIFO on push: the byte is dropped, overflow sets, and drop_count increments, saturating at 255.
- Push and pop in the same cycle are both honoured, including when the FIFO is full (the pop frees the slot and the push succeeds).
- clr_stats clears overflow and drop_count.
  - If a drop coincides with clr_stats, the result is overflow=1, drop_count=1.
- Drain FSM:
  - IDLE: if the FIFO is non-empty, go to REQ.
  - REQ: bus_req=1. When bus_gnt && !ft240x_TXE, go to SETUP.
  - SETUP: ft_d_oe=1, ft_d_out=head, nWR high, for 1 cycle. Then go to STROBE.
  - STROBE: nWR low for WR_LOW_CYC cycles. Then go to HOLD.
  - HOLD: nWR high, data still driven, for 1 cycle. The FIFO pops at the end of HOLD. Then go to GAP.
  - GAP: bus_req=0, ft_d_oe=0, for WR_GAP_CYC cycles. Then go to IDLE.
- Bus and handshake rules:
  - bus_req stays high from REQ through HOLD.
  - If bus_gnt drops in SETUP, STROBE or HOLD, the current write still completes.
  - The FT240X latches data on the nWR falling edge.
- TXE rising after REQ has been left does not abort the current write. TXE is only checked in REQ.
- Deasserting enable stops capture only. Queued bytes still drain.
- FIFO pointers are log2(DEPTH)+1 bits wide and wrap naturally. Full means the MSBs differ and the low bits are equal.

## Timing
- Reset values: bus_req=0, ft_d_oe=0, ft_d_out=0, ft240x_nWR=1, overflow=0, drop_count=0. The FIFO is empty and the FSM is in IDLE.
- Latency from target strobe edge to push: 3 cycles (2 synchroniser cycles plus 1 edge-detect cycle).
- From push to nWR falling, with bus_gnt held and TXE low: 4 cycles (IDLE, REQ, SETUP, then the STROBE edge).
- Sustained rate with defaults: one byte per 6 cycles.
- Reset asserted mid-write: all outputs return to their reset values in the next cycle, and the FIFO contents are discarded.
- ft240x_nWR, ft_d_oe and bus_req are registered outputs with no combinational paths.

## Configuration
- EXFIL_DROP_COUNT_EN defined: the 8-bit saturating drop_count is implemented.
- Undefined: drop_count is tied to 0 and no counter register exists. The overflow flag is always present.

## Structure
- Package exfil_pkg holds:
  - FSM state enum (IDLE, REQ, SETUP, STROBE, HOLD, GAP).
  - EXFIL_PAGE_W=10.
  - DROP_CNT_W=8.
- Sub-module exfil_fifo: a synchronous FIFO with DEPTH and WIDTH=8 parameters, outputs full, empty and head, and simultaneous push/pop.
- Synchroniser, edge detect, compare, stats and drain FSM live in exfil_tx.

## Test plan
- enable=1, match_page=0x3A5, single access at 0x3A512 with bus_gnt=1 and TXE=0 -> exactly one write of 0x12, nWR low for 1 cycle, ft_d_oe high for 3 cycles.
- Access at 0x3A612 with match_page=0x3A5, then a matching access with enable=0 -> no bus_req and no writes.
- TXE=1 held, 10 matching accesses with DEPTH=8 -> 8 bytes queued, overflow=1, drop_count=2. After TXE drops -> 8 writes in order.
- Access while the FIFO is full, coinciding with the HOLD pop -> push accepted, no drop.
- bus_gnt withheld for 20 cycles -> bus_req held high, nWR stays high. Grant arrives -> write proceeds.
- rst pulsed during STROBE -> nWR=1, ft_d_oe=0 and bus_req=0 the next cycle, FIFO empty, no further writes.
